// File: rtl/seq_pkg.sv
// Shared definitions for the 3-bit sequence lock monitor:
// the generator table (6,3,5,7,2,1), monitor states and the successor/legality lookup.
package seq_pkg;

  localparam int SEQ_LEN = 6;

  localparam logic [2:0] SEQ_VAL [SEQ_LEN] = '{3'd6, 3'd3, 3'd5, 3'd7, 3'd2, 3'd1};

  // Value expected right after reset / while hunting, and the value that closes a period
  localparam logic [2:0] SEQ_FIRST = 3'd6;
  localparam logic [2:0] SEQ_LAST  = 3'd1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  // Returns {succ[2:0], legal}. Illegal values (0 and 4) give succ=0, legal=0.
  function automatic logic [3:0] seq_lookup(input logic [2:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (v == SEQ_VAL[i]) begin
        r = {SEQ_VAL[(i + 1) % SEQ_LEN], 1'b1};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_succ_lut.sv
// Combinational successor/legality lookup for one 3-bit sequence value.
module seq_succ_lut
  import seq_pkg::*;
(
  input  logic [2:0] value,
  output logic [2:0] succ,
  output logic       legal
);

  // Table lookup: successor in the generator cycle and whether the value occurs at all
  always_comb begin
    {succ, legal} = seq_lookup(value);
  end

endmodule

// File: rtl/seq_lock_monitor.sv
// In-system checker for the 6,3,5,7,2,1 sequence generator.
// Hunts for a legal value, requires LOCK_CNT in-order samples to lock, then flags
// every deviation, counting mismatches (saturating) and completed periods (wrapping).
// Optional: define SEQ_MON_STICKY_EN to add the err_sticky output, set by the first
// mismatch and cleared only by rst.
module seq_lock_monitor
  import seq_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  parameter int PER_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       seq_in,
  input  logic             valid_in,
  output logic             locked,
  output logic             mismatch,
  output logic             period_done,
  output logic [ERR_W-1:0] err_cnt,
  output logic [PER_W-1:0] period_cnt,
`ifdef SEQ_MON_STICKY_EN
  output logic             err_sticky,
`endif
  output logic [2:0]       exp_next
);

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

  mon_state_t state;
  logic [2:0] match_cnt;
  logic [2:0] last;

  logic [2:0] last_succ;
  logic       last_legal;
  logic [2:0] in_succ;
  logic       in_legal;
  logic       is_succ;
  logic [2:0] match_nxt;

  // Successor of the last accepted sample: what the incoming sample must equal
  seq_succ_lut u_last_lut (
    .value (last),
    .succ  (last_succ),
    .legal (last_legal)
  );

  // Legality of the incoming sample, and its successor for the next exp_next
  seq_succ_lut u_in_lut (
    .value (seq_in),
    .succ  (in_succ),
    .legal (in_legal)
  );

  // In-order test and next match count
  always_comb begin
    is_succ   = last_legal && (seq_in == last_succ);
    match_nxt = match_cnt + 3'd1;
  end

  // Lock FSM, error/period counters and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      match_cnt   <= 3'd0;
      last        <= 3'd0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      period_done <= 1'b0;
      err_cnt     <= '0;
      period_cnt  <= '0;
      exp_next    <= SEQ_FIRST;
`ifdef SEQ_MON_STICKY_EN
      err_sticky  <= 1'b0;
`endif
    end else begin
      mismatch    <= 1'b0;
      period_done <= 1'b0;
      if (valid_in) begin
        case (state)
          HUNT: begin
            if (in_legal) begin
              last      <= seq_in;
              match_cnt <= 3'd1;
              exp_next  <= in_succ;
              state     <= SYNC;
            end else begin
              exp_next  <= SEQ_FIRST;
            end
          end
          SYNC: begin
            if (is_succ) begin
              last     <= seq_in;
              exp_next <= in_succ;
              match_cnt <= match_nxt;
              if (match_nxt >= LOCK_TGT) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                state  <= SYNC;
              end
            end else if (in_legal) begin
              // Legal but out of order: treat it as a fresh first sample
              last      <= seq_in;
              match_cnt <= 3'd1;
              exp_next  <= in_succ;
            end else begin
              state     <= HUNT;
              match_cnt <= 3'd0;
              last      <= 3'd0;
              exp_next  <= SEQ_FIRST;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              last     <= seq_in;
              exp_next <= in_succ;
              if (seq_in == SEQ_LAST) begin
                period_done <= 1'b1;
                period_cnt  <= period_cnt + PER_W'(1);
              end else begin
                period_cnt  <= period_cnt;
              end
            end else begin
              // Deviation: the offending sample is dropped, re-sync starts from HUNT
              mismatch  <= 1'b1;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end else begin
                err_cnt <= err_cnt;
              end
              locked    <= 1'b0;
              state     <= HUNT;
              match_cnt <= 3'd0;
              last      <= 3'd0;
              exp_next  <= SEQ_FIRST;
`ifdef SEQ_MON_STICKY_EN
              err_sticky <= 1'b1;
`endif
            end
          end
          default: begin
            state     <= HUNT;
            match_cnt <= 3'd0;
            last      <= 3'd0;
            locked    <= 1'b0;
            exp_next  <= SEQ_FIRST;
          end
        endcase
      end else begin
        state <= state;
      end
    end
  end

endmodule

// File: tb/tb_seq_lock_monitor.sv
// Scoreboard bench for seq_lock_monitor: each stimulus step pushes its expected
// outputs; a monitor pops one entry per clock and compares. A second instance with
// ERR_W=2 shares the inputs to show error-counter saturation.
module tb_seq_lock_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  seq_in;
  logic        valid_in;

  logic        locked, mismatch, period_done;
  logic [7:0]  err_cnt;
  logic [15:0] period_cnt;
  logic [2:0]  exp_next;
  logic        sticky;

  logic        locked2, mismatch2, period_done2;
  logic [1:0]  err_cnt2;
  logic [15:0] period_cnt2;
  logic [2:0]  exp_next2;
  logic        sticky2;

  seq_lock_monitor #(.LOCK_CNT(3), .ERR_W(8), .PER_W(16)) u_dut (
    .clk(clk), .rst(rst), .seq_in(seq_in), .valid_in(valid_in),
    .locked(locked), .mismatch(mismatch), .period_done(period_done),
    .err_cnt(err_cnt), .period_cnt(period_cnt),
`ifdef SEQ_MON_STICKY_EN
    .err_sticky(sticky),
`endif
    .exp_next(exp_next)
  );

  seq_lock_monitor #(.LOCK_CNT(3), .ERR_W(2), .PER_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .seq_in(seq_in), .valid_in(valid_in),
    .locked(locked2), .mismatch(mismatch2), .period_done(period_done2),
    .err_cnt(err_cnt2), .period_cnt(period_cnt2),
`ifdef SEQ_MON_STICKY_EN
    .err_sticky(sticky2),
`endif
    .exp_next(exp_next2)
  );

`ifndef SEQ_MON_STICKY_EN
  assign sticky  = 1'b0;
  assign sticky2 = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        lk;
    logic        mm;
    logic        pd;
    int          err;
    int          per;
    logic [2:0]  nx;
    logic        st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   e_err  = 0;
  int   e_per  = 0;
  logic e_st   = 1'b0;

  logic [2:0] tbl [6] = '{3'd6, 3'd3, 3'd5, 3'd7, 3'd2, 3'd1};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // One sample cycle: drive inputs at negedge, queue expected post-edge outputs
  task automatic step(input logic [2:0] s, input logic v, input logic lk,
                      input logic mm, input logic pd, input logic [2:0] nx);
    exp_t e;
    @(negedge clk);
    seq_in   = s;
    valid_in = v;
    e.lk = lk; e.mm = mm; e.pd = pd; e.err = e_err; e.per = e_per; e.nx = nx; e.st = e_st;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_mismatch"}, int'(mismatch), 0);
    chk({tag, "_period_done"}, int'(period_done), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_err_cnt2"}, int'(err_cnt2), 0);
    chk({tag, "_period_cnt"}, int'(period_cnt), 0);
    chk({tag, "_exp_next"}, int'(exp_next), 6);
`ifdef SEQ_MON_STICKY_EN
    chk({tag, "_sticky"}, int'(sticky), 0);
`endif
  endtask

  // Monitor: outputs are registered, so each queued entry is due just after the next edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked", int'(locked), int'(e.lk));
        chk("mismatch", int'(mismatch), int'(e.mm));
        chk("period_done", int'(period_done), int'(e.pd));
        chk("err_cnt", int'(err_cnt), e.err);
        chk("err_cnt_sat2", int'(err_cnt2), (e.err > 3) ? 3 : e.err);
        chk("period_cnt", int'(period_cnt), e.per);
        chk("exp_next", int'(exp_next), int'(e.nx));
`ifdef SEQ_MON_STICKY_EN
        chk("err_sticky", int'(sticky), int'(e.st));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] v;
    rst = 1'b1; seq_in = 3'd0; valid_in = 1'b0;
    #1;
    check_reset_values("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean stream x4: lock on the third sample, period_done on every later 1
    for (int k = 0; k < 24; k++) begin
      v = tbl[k % 6];
      if (v == 3'd1 && k >= 5) e_per++;
      step(v, 1'b1, k >= 2, 1'b0, (v == 3'd1 && k >= 5), tbl[(k + 1) % 6]);
    end

    // Locked after 7, inject 4, then relock with 2,1,6
    step(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
    step(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
    step(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
    step(3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    e_err++; e_st = 1'b1;
    step(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6);
    step(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
    step(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6);
    step(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);

    // valid_in low for 5 cycles with seq_in=0: everything holds
    step(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
    repeat (5) step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5);
    step(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
    step(3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    step(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
    e_per++;
    step(3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6);

    // Five locked mismatches, relocking in between (ERR_W=2 instance saturates at 3)
    repeat (5) begin
      step(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
      e_err++;
      step(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6);
      step(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
      step(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
      step(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
      step(3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
      step(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
      e_per++;
      step(3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6);
    end

    // Mid-period asynchronous reset while locked
    step(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
    step(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
    @(negedge clk);
    chk("drain_before_rst", q.size(), 0);
    chk("locked_before_rst", int'(locked), 1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;
    e_err = 0; e_per = 0; e_st = 1'b0;

    // Relock after reset
    step(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    step(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
    step(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
    step(3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    step(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
    e_per++;
    step(3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6);

    // Mismatch into HUNT, then illegal values are ignored silently
    e_err++; e_st = 1'b1;
    step(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6);
    step(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6);
    step(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6);
    step(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6);

    // Relock: sticky flag survives
    step(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    step(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
    step(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
    step(3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);

    @(negedge clk);
    chk("drain_final", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
